// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and operand forwarding for the RV32I execute stage.
// Resolves RAW hazards from MEM/WB and turns load-use hazards into EX bubbles.
module ex_operand_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR      = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     id_valid,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [REG_ADDR-1:0]      id_rs1,
    input  logic [REG_ADDR-1:0]      id_rs2,
    input  logic [REG_ADDR-1:0]      id_rd,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_alusrc,
    input  logic                     id_regwrite,
    input  logic                     id_memread,
    input  logic                     mem_regwrite,
    input  logic [REG_ADDR-1:0]      mem_rd,
    input  logic [DATA_WIDTH-1:0]    mem_result,
    input  logic                     wb_regwrite,
    input  logic [REG_ADDR-1:0]      wb_rd,
    input  logic [DATA_WIDTH-1:0]    wb_result,
    output logic                     ex_valid,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [REG_ADDR-1:0]      ex_rd,
    output logic                     ex_regwrite,
    output logic                     ex_memread,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic                     load_use_hazard
);

    logic                     r_valid;
    logic [DATA_WIDTH-1:0]    r_rs1_data;
    logic [DATA_WIDTH-1:0]    r_rs2_data;
    logic [DATA_WIDTH-1:0]    r_imm;
    logic [REG_ADDR-1:0]      r_rs1;
    logic [REG_ADDR-1:0]      r_rs2;
    logic [REG_ADDR-1:0]      r_rd;
    logic [OPCODE_LENGTH-1:0] r_alu_op;
    logic                     r_alusrc;
    logic                     r_regwrite;
    logic                     r_memread;

    logic                     w_load_use;
    logic                     w_bubble;
    logic                     w_load;
    logic [DATA_WIDTH-1:0]    w_fwd_a;
    logic [DATA_WIDTH-1:0]    w_fwd_b;

    // MEM is the younger producer so it wins over WB; x0 always reads the register file value.
    function automatic logic [DATA_WIDTH-1:0] f_forward(
        input logic [REG_ADDR-1:0]   rs,
        input logic [DATA_WIDTH-1:0] rf_data,
        input logic                  m_we,
        input logic [REG_ADDR-1:0]   m_rd,
        input logic [DATA_WIDTH-1:0] m_res,
        input logic                  w_we,
        input logic [REG_ADDR-1:0]   w_rd,
        input logic [DATA_WIDTH-1:0] w_res
    );
        logic [DATA_WIDTH-1:0] v;
        if (m_we && (m_rd != {REG_ADDR{1'b0}}) && (m_rd == rs)) begin
            v = m_res;
        end else if (w_we && (w_rd != {REG_ADDR{1'b0}}) && (w_rd == rs)) begin
            v = w_res;
        end else begin
            v = rf_data;
        end
        return v;
    endfunction

    // Hazard detection, update-priority decode and operand forwarding.
    always_comb begin
        w_load_use = r_valid && r_memread && (r_rd != {REG_ADDR{1'b0}}) && id_valid &&
                     ((r_rd == id_rs1) || ((r_rd == id_rs2) && !id_alusrc));
        // flush beats stall, stall beats the load-use bubble
        w_bubble   = flush || (!stall && w_load_use);
        w_load     = !stall;
        w_fwd_a    = f_forward(r_rs1, r_rs1_data, mem_regwrite, mem_rd, mem_result,
                               wb_regwrite, wb_rd, wb_result);
        w_fwd_b    = f_forward(r_rs2, r_rs2_data, mem_regwrite, mem_rd, mem_result,
                               wb_regwrite, wb_rd, wb_result);
    end

    // ID/EX stage register: clear, bubble, hold or capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || w_bubble) begin
            r_valid    <= 1'b0;
            r_rs1_data <= {DATA_WIDTH{1'b0}};
            r_rs2_data <= {DATA_WIDTH{1'b0}};
            r_imm      <= {DATA_WIDTH{1'b0}};
            r_rs1      <= {REG_ADDR{1'b0}};
            r_rs2      <= {REG_ADDR{1'b0}};
            r_rd       <= {REG_ADDR{1'b0}};
            r_alu_op   <= {OPCODE_LENGTH{1'b0}};
            r_alusrc   <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
        end else if (w_load) begin
            r_valid    <= id_valid;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_alu_op   <= id_alu_op;
            r_alusrc   <= id_alusrc;
            r_regwrite <= id_regwrite && id_valid;
            r_memread  <= id_memread && id_valid;
        end else begin
            r_valid    <= r_valid;
            r_rs1_data <= r_rs1_data;
            r_rs2_data <= r_rs2_data;
            r_imm      <= r_imm;
            r_rs1      <= r_rs1;
            r_rs2      <= r_rs2;
            r_rd       <= r_rd;
            r_alu_op   <= r_alu_op;
            r_alusrc   <= r_alusrc;
            r_regwrite <= r_regwrite;
            r_memread  <= r_memread;
        end
    end

    assign ex_valid        = r_valid;
    assign SrcA            = w_fwd_a;
    assign SrcB            = r_alusrc ? r_imm : w_fwd_b;
    assign Operation       = r_alu_op;
    assign ex_rd           = r_rd;
    assign ex_regwrite     = r_regwrite && r_valid;
    assign ex_memread      = r_memread && r_valid;
    assign ex_store_data   = w_fwd_b;
    assign load_use_hazard = w_load_use;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: a per-cycle reference model of the EX
// instruction plus hand-computed literal checks for the key scenarios.
module tb_ex_operand_stage;

    logic        clk, reset, stall, flush, id_valid;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_alusrc, id_regwrite, id_memread;
    logic        mem_regwrite, wb_regwrite;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_result;
    logic        ex_valid, ex_regwrite, ex_memread, load_use_hazard;
    logic [31:0] SrcA, SrcB, ex_store_data;
    logic [3:0]  Operation;
    logic [4:0]  ex_rd;

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    ex_operand_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .ex_valid(ex_valid), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The instruction the model believes is sitting in EX.
    typedef struct packed {
        logic        v;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic        alusrc;
        logic        rw;
        logic        mr;
    } ex_t;

    ex_t m;

    // Value an instruction reading register rs actually needs right now.
    function automatic logic [31:0] resolve(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return rf;
        if (mem_regwrite && mem_rd == rs) return mem_result;
        if (wb_regwrite && wb_rd == rs) return wb_result;
        return rf;
    endfunction

    function automatic logic exp_hazard();
        logic is_load;
        is_load = m.v && m.mr && (m.rd != 5'd0);
        return is_load && id_valid && ((m.rd == id_rs1) || (m.rd == id_rs2 && !id_alusrc));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Model of what EX holds after each edge.
    always @(posedge clk or posedge reset) begin
        if (reset)             m <= '0;
        else if (flush)        m <= '0;
        else if (stall)        m <= m;
        else if (exp_hazard()) m <= '0;
        else m <= '{v: id_valid, rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
                    rs1: id_rs1, rs2: id_rs2, rd: id_rd, op: id_alu_op, alusrc: id_alusrc,
                    rw: id_regwrite && id_valid, mr: id_memread && id_valid};
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_ex_valid", {31'd0, ex_valid}, {31'd0, m.v});
            chk("m_SrcA", SrcA, resolve(m.rs1, m.rs1_data));
            chk("m_SrcB", SrcB, m.alusrc ? m.imm : resolve(m.rs2, m.rs2_data));
            chk("m_Operation", {28'd0, Operation}, {28'd0, m.op});
            chk("m_ex_rd", {27'd0, ex_rd}, {27'd0, m.rd});
            chk("m_ex_regwrite", {31'd0, ex_regwrite}, {31'd0, m.v && m.rw});
            chk("m_ex_memread", {31'd0, ex_memread}, {31'd0, m.v && m.mr});
            chk("m_store_data", ex_store_data, resolve(m.rs2, m.rs2_data));
            chk("m_hazard", {31'd0, load_use_hazard}, {31'd0, exp_hazard()});
        end
    end

    task automatic idle();
        stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_alu_op = 4'd0;
        id_alusrc = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0;
        mem_regwrite = 1'b0; mem_rd = 5'd0; mem_result = 32'd0;
        wb_regwrite = 1'b0; wb_rd = 5'd0; wb_result = 32'd0;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rs2,
                         input logic [31:0] d2, input logic [4:0] rd, input logic [3:0] op,
                         input logic memread);
        id_valid = 1'b1; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
        id_rd = rd; id_alu_op = op; id_regwrite = 1'b1; id_memread = memread;
        id_alusrc = 1'b0; id_imm = 32'd0;
    endtask

    // Advance past one rising edge; inputs may then be changed safely.
    task automatic next();
        @(negedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #1;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_regwrite", {31'd0, ex_regwrite}, 32'd0);
        chk("rst_memread", {31'd0, ex_memread}, 32'd0);
        chk("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
        chk("rst_operation", {28'd0, Operation}, 32'd0);
        next();
        reset = 1'b0;
        chk_en = 1'b1;

        // Pass-through with no forwarding.
        instr(5'd1, 32'd5, 5'd2, 32'd9, 5'd3, 4'b0100, 1'b0);
        next();
        chk("pt_SrcA", SrcA, 32'd5);
        chk("pt_SrcB", SrcB, 32'd9);
        chk("pt_Operation", {28'd0, Operation}, 32'd4);
        chk("pt_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("pt_store", ex_store_data, 32'd9);

        // MEM beats WB; WB used when MEM does not write.
        instr(5'd3, 32'h11, 5'd4, 32'h22, 5'd6, 4'b0000, 1'b0);
        next();
        mem_regwrite = 1'b1; mem_rd = 5'd3; mem_result = 32'hAA;
        wb_regwrite = 1'b1; wb_rd = 5'd3; wb_result = 32'hBB;
        #1 chk("fwd_mem_prio", SrcA, 32'hAA);
        mem_regwrite = 1'b0;
        #1 chk("fwd_wb", SrcA, 32'hBB);
        next();
        wb_rd = 5'd4;
        #1 chk("fwd_wb_store", ex_store_data, 32'hBB);
        chk("fwd_wb_srcb", SrcB, 32'hBB);
        chk("fwd_rf_srca", SrcA, 32'h11);
        idle();

        // x0 is never forwarded.
        instr(5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 4'b0001, 1'b0);
        next();
        mem_regwrite = 1'b1; mem_rd = 5'd0; mem_result = 32'hFF;
        #1 chk("x0_guard", SrcA, 32'd0);
        idle();

        // Load-use: rs1 match bubbles; rs2 match only matters without an immediate.
        instr(5'd1, 32'd1, 5'd2, 32'd2, 5'd7, 4'b0000, 1'b1);
        next();
        instr(5'd7, 32'd0, 5'd0, 32'd0, 5'd8, 4'b0000, 1'b0);
        #1 chk("lu_hazard", {31'd0, load_use_hazard}, 32'd1);
        next();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_rw", {31'd0, ex_regwrite}, 32'd0);
        instr(5'd1, 32'd1, 5'd2, 32'd2, 5'd7, 4'b0000, 1'b1);
        next();
        instr(5'd1, 32'd1, 5'd7, 32'd0, 5'd8, 4'b0000, 1'b0);
        id_alusrc = 1'b1;
        #1 chk("lu_imm_no_hazard", {31'd0, load_use_hazard}, 32'd0);
        id_alusrc = 1'b0;
        #1 chk("lu_rs2_hazard", {31'd0, load_use_hazard}, 32'd1);
        next();

        // Stall freezes EX while ID changes.
        instr(5'd9, 32'h1234, 5'd10, 32'h10, 5'd5, 4'b0010, 1'b0);
        next();
        stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            id_rs1_data = i; id_alu_op = i[3:0]; id_rd = 5'(i + 10);
            next();
            chk("stall_SrcA", SrcA, 32'h1234);
            chk("stall_op", {28'd0, Operation}, 32'd2);
            chk("stall_rd", {27'd0, ex_rd}, 32'd5);
        end
        flush = 1'b1;
        next();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_op", {28'd0, Operation}, 32'd0);
        chk("flush_rd", {27'd0, ex_rd}, 32'd0);
        stall = 1'b0; flush = 1'b0;

        // Immediate reaches SrcB while store data stays the forwarded rs2.
        instr(5'd1, 32'd3, 5'd6, 32'h55, 5'd2, 4'b0000, 1'b0);
        id_alusrc = 1'b1; id_imm = 32'hFFFF_FFFC;
        next();
        wb_regwrite = 1'b1; wb_rd = 5'd6; wb_result = 32'h77;
        #1 chk("imm_SrcB", SrcB, 32'hFFFF_FFFC);
        chk("imm_store", ex_store_data, 32'h77);

        // Asynchronous reset while EX is busy.
        id_memread = 1'b1;
        next();
        chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, ex_valid}, 32'd0);
        chk("midrst_rw", {31'd0, ex_regwrite}, 32'd0);
        chk("midrst_mr", {31'd0, ex_memread}, 32'd0);
        chk("midrst_op", {28'd0, Operation}, 32'd0);
        reset = 1'b0;
        idle();
        next();
        next();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
ID/EX pipeline register and operand-forwarding front end of the RV32I execute stage. Captures decoded operands and control from ID. Resolves RAW hazards by forwarding results from MEM and WB. Presents the resolved SrcA, SrcB and Operation directly to the ALU and its operation wrappers (e.g. SLT). Detects load-use hazards and inserts bubbles.

Parameters:
DATA_WIDTH, 32, datapath width
OPCODE_LENGTH, 4, ALU Operation code width
REG_ADDR, 5, register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hold all stage registers
flush  in  1  kill the instruction entering EX (branch/jump redirect)
id_valid  in  1  ID holds a real instruction
id_rs1_data  in  DATA_WIDTH  register-file read port 1
id_rs2_data  in  DATA_WIDTH  register-file read port 2
id_imm  in  DATA_WIDTH  sign-extended immediate
id_rs1  in  REG_ADDR  source register 1 index
id_rs2  in  REG_ADDR  source register 2 index
id_rd  in  REG_ADDR  destination index
id_alu_op  in  OPCODE_LENGTH  ALU operation code
id_alusrc  in  1  1: SrcB = immediate
id_regwrite  in  1  writes rd
id_memread  in  1  load instruction
mem_regwrite  in  1  MEM-stage instruction writes rd
mem_rd  in  REG_ADDR  MEM-stage destination
mem_result  in  DATA_WIDTH  MEM-stage ALU result
wb_regwrite  in  1  WB-stage instruction writes rd
wb_rd  in  REG_ADDR  WB-stage destination
wb_result  in  DATA_WIDTH  WB-stage writeback data
ex_valid  out  1  EX holds a real instruction
SrcA  out  DATA_WIDTH  forwarded ALU operand A
SrcB  out  DATA_WIDTH  forwarded operand B or immediate
Operation  out  OPCODE_LENGTH  ALU operation code
ex_rd  out  REG_ADDR  registered destination
ex_regwrite  out  1  registered regwrite, qualified by ex_valid
ex_memread  out  1  registered memread, qualified by ex_valid
ex_store_data  out  DATA_WIDTH  forwarded rs2 value, never the immediate
load_use_hazard  out  1  ID must hold; EX receives a bubble

Behaviour:
- Reset (async, active-high): all stage registers are 0. ex_valid=0, ex_regwrite=0, ex_memread=0, ex_rd=0, Operation=0. Outputs stay at these values until the first clk edge after reset deasserts. Reset asserted mid-stream discards the in-flight instruction immediately.
- Latency: 1 cycle. ID values sampled on edge N appear on the EX outputs after edge N.
- Update priority at each edge: flush > stall > load_use_hazard > normal load.
- flush: ex_valid, ex_regwrite and ex_memread go to 0. All other registers go to 0.
- stall (no flush): all registers hold their values.
- load_use_hazard (no stall/flush): bubble inserted, identical to the flush result.
- Normal load: every id_* field is captured. Control bits are ANDed with id_valid.
- load_use_hazard is combinational and equals ex_valid & ex_memread & (ex_rd!=0) & id_valid & (ex_rd==id_rs1 | (ex_rd==id_rs2 & !id_alusrc)).
- Forwarding is combinational from the registered rs1/rs2. Applied separately to operand A and to the rs2 value:
  - Use mem_result when mem_regwrite & mem_rd!=0 & mem_rd==rs.
  - Else use wb_result when wb_regwrite & wb_rd!=0 & wb_rd==rs.
  - Else use the registered register-file data.
  - MEM has priority when MEM and WB both match.
  - x0 (index 0) is never forwarded.
- SrcA = forwarded rs1 value.
- SrcB = id_alusrc_reg ? imm_reg : forwarded rs2 value.
- ex_store_data = forwarded rs2 value.
- The register file resolves same-cycle WB write / ID read. This block does not bypass WB into the ID capture path.
- Forwarding is evaluated even when ex_valid=0. Downstream must gate on ex_valid.

Test Plan:
- Reset mid-operation: reset pulse while ex_valid=1 -> ex_valid, ex_regwrite, ex_memread and Operation are 0 immediately, before any clk edge.
- Pass-through: id_rs1_data=5, id_rs2_data=9, id_alu_op=4'b0100, id_alusrc=0, no forwarding -> next cycle SrcA=5, SrcB=9, Operation=0100, ex_valid=1.
- Forward priority: rs1=3, mem_rd=3 with mem_result=0xAA, wb_rd=3 with wb_result=0xBB (both regwrite=1) -> SrcA=0xAA. With mem_regwrite=0 -> SrcA=0xBB.
- x0 guard: rs1=0, mem_rd=0, mem_regwrite=1, mem_result=0xFF, id_rs1_data=0 -> SrcA=0.
- Load-use bubble: EX holds a load with rd=7; ID has rs1=7 -> load_use_hazard=1. Next edge ex_valid=0 and ex_regwrite=0. With id_alusrc=1 and only rs2=7 -> load_use_hazard=0.
- Stall/flush: stall=1 for 3 cycles with changing id_* -> outputs frozen. flush and stall both 1 -> bubble (flush wins). Immediate path: id_alusrc=1, id_imm=0xFFFFFFFC -> SrcB=0xFFFFFFFC while ex_store_data still shows the forwarded rs2 value.
